// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_N transmitter between several producers.
// Define UART_TX_ARBITER_TIMEOUT_EN to enable the launch timeout counter and err pulse.
module uart_tx_arbiter #(
    parameter int unsigned requesters  = 4,
    parameter int unsigned word_width  = 8,
    parameter int unsigned ack_timeout = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [requesters-1:0]              req,
    input  logic [requesters*word_width-1:0]   req_data,
    output logic [requesters-1:0]              ack,
    output logic [requesters-1:0]              done,
    output logic                               err,
    output logic                               busy,
    output logic                               write,
    output logic [word_width-1:0]              T_W,
    input  logic                               T_locked
);

    localparam int unsigned IW = $clog2(requesters);

    if (requesters < 2 || ack_timeout < 2) begin : g_bad_params
        $error("uart_tx_arbiter: requesters and ack_timeout must both be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, LAUNCH, BUSY} state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [IW-1:0]           last, last_n;
    logic [IW-1:0]           grant_idx, cand;
    logic                    grant_found;
    logic [word_width-1:0]   word, word_n;
    logic [requesters-1:0]   ack_n, done_n;
    logic                    write_n, busy_n;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(ack_timeout);
    logic [CW-1:0]           cnt, cnt_n;
    logic                    err_n;
`endif

    assign T_W = word;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= requesters; i++) begin
            cand = IW'((32'(last) + i) % requesters);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last;
        word_n  = word;
        ack_n   = '0;
        done_n  = '0;
        write_n = 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        cnt_n   = cnt;
        err_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // The done cycle is a settling cycle: no grant while done is high.
                if (grant_found && !T_locked && done == '0) begin
                    state_n          = ISSUE;
                    idx_n            = grant_idx;
                    word_n           = req_data[grant_idx*word_width +: word_width];
                    write_n          = 1'b1;
                    ack_n[grant_idx] = 1'b1;
                end
            end
            ISSUE: begin
                state_n = LAUNCH;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
            LAUNCH: begin
                if (T_locked) begin
                    state_n = BUSY;
                end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                else begin
                    cnt_n = cnt + 1'b1;
                    if (cnt_n == CW'(ack_timeout - 1)) begin
                        err_n   = 1'b1;
                        last_n  = idx;
                        state_n = IDLE;
                    end
                end
`endif
            end
            BUSY: begin
                if (!T_locked) begin
                    done_n[idx] = 1'b1;
                    last_n      = idx;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            last  <= IW'(requesters - 1);
            word  <= '0;
            ack   <= '0;
            done  <= '0;
            write <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            last  <= last_n;
            word  <= word_n;
            ack   <= ack_n;
            done  <= done_n;
            write <= write_n;
            busy  <= busy_n;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_n;
            err <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UART busy-flag model and a grant scoreboard.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack, done;
    logic        err, busy, write;
    logic [7:0]  T_W;
    logic        T_locked;

    logic        model_lock = 1'b0;
    logic        ext_lock   = 1'b0;
    logic        uart_en    = 1'b1;
    int          uart_delay = 2;
    int          uart_hold  = 20;

    int          n_pass = 0, n_total = 0, n_fail = 0;
    int          cyc = 0, write_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          write_cyc = 0, err_cyc = 0;
    logic [3:0]  last_done = '0;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    assign T_locked = model_lock | ext_lock;

    uart_tx_arbiter #(
        .requesters (4),
        .word_width (8),
        .ack_timeout(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .write   (write),
        .T_W     (T_W),
        .T_locked(T_locked)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.ack  = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_write(input string tag, input int maxc);
        int k = 0;
        while (write !== 1'b1 && k < maxc) begin
            tick();
            k++;
        end
        check({tag, "_write_seen"}, 32'(write), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int maxc, input logic [3:0] expv);
        int k = 0;
        while (done === 4'b0000 && k < maxc) begin
            tick();
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'(expv));
    endtask

    // UART model: raise T_locked uart_delay cycles after write, hold for uart_hold cycles.
    initial forever begin
        @(negedge clk);
        if (write === 1'b1 && uart_en) begin
            repeat (uart_delay) @(negedge clk);
            model_lock = 1'b1;
            repeat (uart_hold) @(negedge clk);
            model_lock = 1'b0;
        end
    end

    // Scoreboard: every write must match the next expected grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (write === 1'b1) begin
                write_cnt++;
                write_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write_ack_tw", {20'h0, ack, T_W}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", 32'(ack), 32'(e.ack));
                    check("T_W", 32'(T_W), 32'(e.data));
                end
            end else if (ack !== 4'b0000) begin
                check("stray_ack", 32'(ack), 32'h0);
            end
            if (done !== 4'b0000) begin
                done_cnt++;
                last_done = done;
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_w, base_d, base_e, wcyc;
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        tick(3);
        check("rst_ack",   32'(ack),   32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_err",   32'(err),   32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_T_W",   32'(T_W),   32'h0);
        rst_n = 1'b1;
        tick(2);

        // Single request from requester 2.
        req_data = 32'h00A5_0000;
        req      = 4'b0100;
        push_exp(4'b0100, 8'hA5);
        wait_write("single", 10);
        req = 4'b0000;
        wait_done("single", 60, 4'b0100);
        tick();
        check("single_busy_after", 32'(busy), 32'h0);
        check("single_write_count", 32'(write_cnt), 32'd1);
        check("single_done_count", 32'(done_cnt), 32'd1);

        // Fairness from a fresh reset: 0,1,2,3,0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        base_w   = write_cnt;
        base_d   = done_cnt;
        req_data = 32'h1312_1110;
        push_exp(4'b0001, 8'h10);
        push_exp(4'b0010, 8'h11);
        push_exp(4'b0100, 8'h12);
        push_exp(4'b1000, 8'h13);
        push_exp(4'b0001, 8'h10);
        req = 4'b1111;
        for (int k = 0; k < 200 && write_cnt < base_w + 5; k++) tick();
        req = 4'b0000;
        check("fair_write_count", 32'(write_cnt - base_w), 32'd5);
        for (int k = 0; k < 60 && done_cnt < base_d + 5; k++) tick();
        check("fair_done_count", 32'(done_cnt - base_d), 32'd5);
        check("fair_queue_empty", 32'(exp_q.size()), 32'd0);
        tick(3);

        // UART already busy when the request arrives.
        base_w   = write_cnt;
        ext_lock = 1'b1;
        req_data = 32'h0000_003C;
        req      = 4'b0001;
        push_exp(4'b0001, 8'h3C);
        tick(10);
        check("locked_no_write", 32'(write_cnt - base_w), 32'd0);
        ext_lock = 1'b0;
        tick();
        check("locked_write_next", 32'(write), 32'd1);
        req = 4'b0000;
        wait_done("locked", 60, 4'b0001);
        tick(3);

        // Withdrawal: req[1] pulsed while requester 0 is in BUSY.
        req_data = 32'h0000_005A;
        req      = 4'b0001;
        push_exp(4'b0001, 8'h5A);
        wait_write("withdraw", 10);
        base_w = write_cnt;
        req    = 4'b0000;
        tick(6);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        wait_done("withdraw", 60, 4'b0001);
        tick(4);
        check("withdraw_no_grant", 32'(write_cnt - base_w), 32'd0);
        check("withdraw_idle", 32'(busy), 32'h0);

        // Launch timeout: the UART never answers.
        uart_en  = 1'b0;
        base_d   = done_cnt;
        base_e   = err_cnt;
        req_data = 32'h9977_0000;
        req      = 4'b0100;
        push_exp(4'b0100, 8'h77);
        wait_write("timeout", 10);
        wcyc = write_cyc;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        req = 4'b1000;
        push_exp(4'b1000, 8'h99);
        for (int k = 0; k < 40 && err_cnt == base_e; k++) tick();
        uart_en = 1'b1;
        check("timeout_err_seen", 32'(err_cnt - base_e), 32'd1);
        check("timeout_err_delay", 32'(err_cyc - wcyc), 32'd16);
        check("timeout_no_done", 32'(done_cnt - base_d), 32'd0);
        wait_write("timeout_next", 10);
        req = 4'b0000;
        wait_done("timeout_next", 60, 4'b1000);
`else
        req = 4'b0000;
        tick(25);
        check("notimeout_err_low", 32'(err_cnt - base_e), 32'd0);
        check("notimeout_still_busy", 32'(busy), 32'd1);
        check("notimeout_no_done", 32'(done_cnt - base_d), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        uart_en = 1'b1;
`endif
        tick(3);

        // Reset asserted while BUSY.
        req_data = 32'h0000_4211;
        req      = 4'b0010;
        push_exp(4'b0010, 8'h42);
        wait_write("rstbusy", 10);
        req = 4'b0000;
        tick(6);
        base_d = done_cnt;
        rst_n  = 1'b0;
        #1;
        check("rstbusy_ack",   32'(ack),   32'h0);
        check("rstbusy_done",  32'(done),  32'h0);
        check("rstbusy_err",   32'(err),   32'h0);
        check("rstbusy_busy",  32'(busy),  32'h0);
        check("rstbusy_write", 32'(write), 32'h0);
        check("rstbusy_T_W",   32'(T_W),   32'h0);
        tick();
        rst_n = 1'b1;
        req   = 4'b0011;
        push_exp(4'b0001, 8'h11);
        wait_write("rstbusy_next", 40);
        check("rstbusy_unlocked_at_write", 32'(T_locked), 32'h0);
        check("rstbusy_no_done", 32'(done_cnt - base_d), 32'd0);
        req = 4'b0000;
        wait_done("rstbusy_next", 60, 4'b0001);
        tick(3);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the transmit side of one `UART_N` instance between `requesters` independent producers. It latches a winner's word, issues a single-cycle `write` to the UART, tracks the UART's `T_locked` busy flag through launch and completion, and returns per-requester acknowledge/done pulses. It sits between the producer blocks (counters, cache front-ends, adder result logic) and the `UART_N` `write` / `T_W` / `T_locked` pins.

## Interface
- `requesters`, 4: number of requesting ports, ≥2.
- `word_width`, 8: UART word width; must equal `UART_N.word_width`.
- `ack_timeout`, 16: cycles allowed for `T_locked` to rise after `write`; ≥2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in `requesters`: per-requester transmit request, level.
- `req_data` in `requesters*word_width`: word for requester i at `[i*word_width +: word_width]`.
- `ack` out `requesters`: one-hot, 1-cycle pulse; word of that requester captured.
- `done` out `requesters`: one-hot, 1-cycle pulse; that requester's word fully sent.
- `err` out 1: 1-cycle pulse on launch timeout.
- `busy` out 1: high whenever state ≠ IDLE.
- `write` out 1: to `UART_N.write`.
- `T_W` out `word_width`: to `UART_N.T_W`.
- `T_locked` in 1: from `UART_N.T_locked`.

## Operation
- States: IDLE, ISSUE, LAUNCH, BUSY.
- IDLE: if `req != 0` and `T_locked == 0`, select the winner by round-robin. Search starts at `last+1` and wraps modulo `requesters`. Register the winner's index into `idx` and its `req_data` slice into `word`. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): `write=1`, `T_W=word`, `ack[idx]=1`. Clear the timeout counter and go to LAUNCH.
- LAUNCH: if `T_locked==1`, go to BUSY. Otherwise increment the counter. When the counter reaches `ack_timeout-1`, pulse `err`, set `last=idx`, return to IDLE, and emit no `done`.
- BUSY: when `T_locked==0`, pulse `done[idx]`, set `last=idx`, and return to IDLE.
- `T_W` holds `word` in all states. It updates only on the IDLE→ISSUE edge.
- `write` is high only in ISSUE.
- Requester contract: hold `req` and data until `ack`. After `ack`, `req` and data may change freely. Dropping `req` before `ack` withdraws the request with no side effects.
- `req` is not sampled outside IDLE. A requester still asserting `req` after its `done` competes normally but has lowest priority because `last=idx`.
- Timeout counter width: `$clog2(ack_timeout)`. No wrap is possible because the counter exits at `ack_timeout-1`.
- Reset values:
  - state IDLE, `last=requesters-1` (requester 0 wins first), `idx=0`, `word=0`, counter 0.
  - All outputs 0.
- Reset asserted mid-transfer: return to IDLE immediately with no `done` or `err`. The UART may finish its frame on its own, and the arbiter waits for `T_locked==0` before the next issue.

## Timing
- `req` high at edge N while IDLE and the UART is free:
  - ISSUE during cycle N+1, with `write` and `ack`.
  - LAUNCH from N+2.
- `done` is asserted the cycle after `T_locked` is seen low in BUSY. The next grant's ISSUE is no earlier than 2 cycles after `done`.
- Minimum issue-to-issue spacing is 4 cycles plus the UART frame time.
- Timeout: `err` is registered and asserts `ack_timeout` cycles after the ISSUE cycle. IDLE follows on the next cycle.
- All outputs are registered; there are no combinational paths from `req`/`T_locked` to any output.

## Configuration
- `UART_TX_ARBITER_TIMEOUT_EN` defined:
  - LAUNCH timeout counter and `err` are present, as described above.
- `UART_TX_ARBITER_TIMEOUT_EN` not defined:
  - No counter; LAUNCH waits for `T_locked==1` indefinitely.
  - `err` is tied to 0; the port remains.
  - `ack_timeout` is ignored.

## Test plan
- Single request: after reset, `req=4'b0100`, slice 2=`8'hA5`, UART model raises `T_locked` 2 cycles after `write` and holds it 20 cycles. Required:
  - one `write` with `T_W=8'hA5`;
  - `ack=4'b0100` in the same cycle;
  - `done=4'b0100` once after `T_locked` falls;
  - `busy` low afterwards.
- Fairness: `req=4'b1111` held continuously with distinct data 8'h10..8'h13. Required:
  - grants in order 0,1,2,3,0;
  - `T_W` sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- UART busy at idle: `T_locked=1` externally with `req=4'b0001`. Required:
  - no `write` until `T_locked` drops;
  - `write` then follows 1 cycle later.
- Withdrawal: `req[1]` pulsed for 1 cycle while the arbiter is in BUSY for requester 0. Required:
  - no grant to 1;
  - after `done[0]`, state is IDLE with no `write`.
- Timeout (macro defined, `ack_timeout=16`): UART never raises `T_locked`. Required:
  - `err` pulses 16 cycles after `write`;
  - no `done`;
  - the next pending requester is granted afterwards.
- Reset in BUSY: `rst_n` low for 1 cycle mid-frame. Required:
  - all outputs 0 immediately;
  - `last` reset, so requester 0 is favoured;
  - no `write` until `T_locked==0`.
